// File: rtl/vga_scanout.sv
// vga_scanout: turns raster timing (x/y/visible/syncs) into palette colour.
// Issues a framebuffer read for every visible pixel (2x doubled in both axes),
// looks the returned index up in a 256x12 palette and presents registered
// colour together with hsync/vsync/frame_start, all delayed by
// L = FB_LATENCY + 2 cycles so that everything leaves aligned.
//
// Ports:
//   clk, rst                 pixel clock, synchronous active-high reset
//   hsync_in, vsync_in       raster syncs (active-high)
//   x_in, y_in, visible_in   raster position and active-area flag
//   fb_rd_en, fb_addr        framebuffer read request (combinational)
//   fb_rd_data               palette index, valid FB_LATENCY cycles later
//   pal_we/pal_addr/pal_wdata palette write port, {R,G,B} 4 bits each
//   vga_r/g/b, hsync, vsync  registered video outputs
//   frame_start              one-cycle pulse with pixel (0,0) on the outputs
module vga_scanout #(
    parameter int unsigned FB_WIDTH    = 320,
    parameter int unsigned FB_LATENCY  = 2,
    parameter int unsigned INDEX_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH  = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic [INDEX_WIDTH-1:0] x_in,
    input  logic [INDEX_WIDTH-1:0] y_in,
    input  logic                   visible_in,
    output logic                   fb_rd_en,
    output logic [ADDR_WIDTH-1:0]  fb_addr,
    input  logic [7:0]             fb_rd_data,
    input  logic                   pal_we,
    input  logic [7:0]             pal_addr,
    input  logic [11:0]            pal_wdata,
    output logic [3:0]             vga_r,
    output logic [3:0]             vga_g,
    output logic [3:0]             vga_b,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   frame_start
);

    // Total pipeline depth; the output register is the last stage, so the
    // tag shift register itself is one stage shorter.
    localparam int unsigned LAT       = FB_LATENCY + 2;
    localparam int unsigned DLY_DEPTH = LAT - 1;
    localparam int unsigned TAG_W     = 4;
    localparam int unsigned PAL_W     = 12;
    localparam int unsigned PAL_DEPTH = 256;

    // Bit positions inside a delay-line tag.
    localparam int unsigned TAG_HS    = 0;
    localparam int unsigned TAG_VS    = 1;
    localparam int unsigned TAG_VIS   = 2;
    localparam int unsigned TAG_FIRST = 3;

    logic                          w_first;
    logic [TAG_W-1:0]              w_tag;
    logic [ADDR_WIDTH-1:0]         w_addr_calc;
    logic                          w_rd_vis;
    logic [7:0]                    w_pal_idx;
    logic [TAG_W-1:0]              w_out_tag;

    logic [DLY_DEPTH-1:0][TAG_W-1:0] r_dly;
    logic [PAL_W-1:0]              r_pal [PAL_DEPTH];
    logic [PAL_W-1:0]              r_pal_q;

    // Stage 0: per-pixel tag that rides alongside the framebuffer read.
    assign w_first = visible_in && (x_in == '0) && (y_in == '0);
    assign w_tag   = {w_first, visible_in, vsync_in, hsync_in};

    // Pixel doubling: each framebuffer byte covers a 2x2 block of screen pixels.
    assign w_addr_calc = ADDR_WIDTH'(y_in >> 1) * ADDR_WIDTH'(FB_WIDTH)
                       + ADDR_WIDTH'(x_in >> 1);

    // Framebuffer read request; address parked at zero outside the active area.
    always_comb begin
        fb_rd_en = visible_in;
        fb_addr  = '0;
        if (visible_in) begin
            fb_addr = w_addr_calc;
        end
    end

    // Tag delay line; stage i holds the tag of the pixel issued i+1 cycles ago.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly <= '0;
        end else begin
            r_dly <= {r_dly[DLY_DEPTH-2:0], w_tag};
        end
    end

    // Tag of the pixel whose framebuffer data is arriving this cycle. Blanked
    // pixels read entry 0 so an undriven fb_rd_data never reaches the palette.
    assign w_rd_vis  = r_dly[FB_LATENCY-1][TAG_VIS];
    assign w_pal_idx = w_rd_vis ? fb_rd_data : 8'h00;

    // Palette: read-first on a same-index write, never reset, writable in reset.
    always_ff @(posedge clk) begin
        if (pal_we) begin
            r_pal[pal_addr] <= pal_wdata;
        end
        r_pal_q <= r_pal[w_pal_idx];
    end

    assign w_out_tag = r_dly[DLY_DEPTH-1];

    // Output register: colour blanked outside the active area.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r       <= 4'h0;
            vga_g       <= 4'h0;
            vga_b       <= 4'h0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (w_out_tag[TAG_VIS]) begin
                vga_r <= r_pal_q[11:8];
                vga_g <= r_pal_q[7:4];
                vga_b <= r_pal_q[3:0];
            end else begin
                vga_r <= 4'h0;
                vga_g <= 4'h0;
                vga_b <= 4'h0;
            end
            hsync       <= w_out_tag[TAG_HS];
            vsync       <= w_out_tag[TAG_VS];
            frame_start <= w_out_tag[TAG_FIRST];
        end
    end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter FB_WIDTH, default 320: framebuffer pixels per row; display is 2x pixel-doubled in both axes.
REQ-002 Parameter FB_LATENCY, default 2: fixed cycles from fb_rd_en to valid fb_rd_data; legal range 1..8.
REQ-003 Parameter INDEX_WIDTH, default 32: width of x_in/y_in.
REQ-004 Parameter ADDR_WIDTH, default 17: width of fb_addr.
REQ-005 clk  input  1  pixel clock (25 MHz); the only clock.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 hsync_in  input  1  horizontal sync from the timing counter, active-high.
REQ-008 vsync_in  input  1  vertical sync from the timing counter, active-high.
REQ-009 x_in  input  INDEX_WIDTH  visible-area column; meaningful only when visible_in=1.
REQ-010 y_in  input  INDEX_WIDTH  visible-area row; meaningful only when visible_in=1.
REQ-011 visible_in  input  1  current pixel lies in the active area.
REQ-012 fb_rd_en  output  1  framebuffer read strobe.
REQ-013 fb_addr  output  ADDR_WIDTH  framebuffer byte address.
REQ-014 fb_rd_data  input  8  palette index returned FB_LATENCY cycles after fb_rd_en.
REQ-015 pal_we  input  1  palette write enable.
REQ-016 pal_addr  input  8  palette write index.
REQ-017 pal_wdata  input  12  palette entry {R[3:0],G[3:0],B[3:0]}.
REQ-018 vga_r / vga_g / vga_b  output  4 each  registered colour outputs.
REQ-019 hsync / vsync  output  1 each  sync delayed to align with colour.
REQ-020 frame_start  output  1  one-cycle pulse coincident with output of pixel (0,0).

Function
REQ-021 Total latency L = FB_LATENCY+2 cycles: input at cycle n appears on vga_*/hsync/vsync at cycle n+L (4 with defaults).
REQ-022 Stage 0 (combinational from inputs): fb_rd_en = visible_in; fb_addr = (y_in>>1)*FB_WIDTH + (x_in>>1), truncated to ADDR_WIDTH.
REQ-023 fb_addr when visible_in=0: 0.
REQ-024 hsync_in, vsync_in, visible_in and a first-pixel flag (visible_in & x_in==0 & y_in==0) travel through an L-deep shift register; no other input is delayed.
REQ-025 Palette: 256x12 storage, synchronous read, one cycle, indexed by fb_rd_data at stage FB_LATENCY.
REQ-026 Palette write and read of the same index in the same cycle: read returns the old entry (read-first).
REQ-027 Output register: if delayed visible=1, {vga_r,vga_g,vga_b} = palette entry; else all zero (blanking).
REQ-028 hsync/vsync outputs equal hsync_in/vsync_in delayed by L cycles, registered, polarity unchanged.
REQ-029 frame_start = delayed first-pixel flag; high for exactly one cycle per frame.
REQ-030 Back-to-back reads every cycle are supported; no stall or backpressure exists.
REQ-031 fb_rd_data is sampled only when the matching delayed visible bit is 1; otherwise it is ignored (X-tolerant).
REQ-032 Max address with defaults: (239*320)+319 = 76799, which fits ADDR_WIDTH=17.

Reset
REQ-033 While rst=1 at a clock edge: all delay-line bits, vga_r/g/b, hsync, vsync, frame_start cleared to 0 the next cycle.
REQ-034 Palette contents are not reset; pal_we is honoured even while rst=1.
REQ-035 Reset mid-line: outputs are 0 for L cycles after rst deasserts, then track inputs with latency L.

Verification
REQ-036 Reset held 3 cycles with visible_in=1 -> outputs all 0 during reset and for 4 cycles after release.
REQ-037 x_in=5, y_in=3, visible_in=1 -> same cycle fb_rd_en=1, fb_addr=322; model returns 0x07 2 cycles later with pal[7]=0xF80 -> 4 cycles later vga_r=F, vga_g=8, vga_b=0.
REQ-038 Full frame from the timing counter (640x480) -> every fb_addr in 0..76799 is read exactly 4 times; hsync/vsync outputs equal inputs shifted 4 cycles; one frame_start per frame, aligned with pixel (0,0).
REQ-039 visible_in=0 with fb_rd_data=0xFF and pal[0xFF]=0xFFF -> vga_* = 0.
REQ-040 pal_we=1, pal_addr=0x10, pal_wdata=0x0F0 on the same cycle the palette reads index 0x10 (old value 0x123) -> that pixel shows 0x123; next pixel reading 0x10 shows 0x0F0.
REQ-041 FB_LATENCY=1 build -> L=3; REQ-037 stimulus yields colour 3 cycles after input.
